// File: rtl/mult23027_inverter.sv
// Recovers x from y = x*23027 mod 2^32 by bit-serial division,
// one result bit per clock, 32 clocks per operand.
module mult23027_inverter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_data0,
    input  logic        i_valid,
    output logic        i_ready,
    output logic [31:0] o_data0,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        o_busy
);

    localparam logic [31:0] C = 32'h0000_59F3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] r;
    logic [31:0] x;
    logic [4:0]  k;

    assign i_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign o_busy  = (state == RUN);
    assign o_data0 = x;

    // C is odd, so bit k of the residual alone decides bit k of x;
    // subtracting C<<k clears that bit without touching lower ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            x     <= '0;
            k     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        r     <= i_data0;
                        x     <= '0;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    x[k] <= r[k];
                    if (r[k]) begin
                        r <= r - (C << k);
                    end
                    k <= k + 5'd1;
                    if (k == 5'd31) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult23027_inverter.sv
// Directed and randomized checks of the 23027 multiplicative inverter
// against expected factors derived from plain modular arithmetic.
module tb_mult23027_inverter;

    localparam logic [31:0] C = 32'd23027;

    logic        clk;
    logic        rst;
    logic [31:0] i_data0;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] o_data0;
    logic        o_valid;
    logic        o_ready;
    logic        o_busy;

    int checks;
    int failures;

    mult23027_inverter dut (
        .clk     (clk),
        .rst     (rst),
        .i_data0 (i_data0),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_data0 (o_data0),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, wait for result, hold, handshake.
    task automatic do_op(input logic [31:0] y, input logic [31:0] exp,
                         input int hold, input bit poke,
                         input bit rnd_ready, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " i_ready"}, {31'd0, i_ready}, 32'd1);
        i_data0 = y;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data0 = $urandom;
        lat = 0;
        while (!o_valid && lat < 100) begin
            if (rnd_ready) o_ready = 1'($urandom);
            if (poke && lat == 5) begin
                i_valid = 1'b1;
                i_data0 = $urandom;
            end else begin
                i_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        o_ready = 1'b0;
        i_valid = 1'b0;
        chk({tag, " latency"}, lat, 32);
        chk({tag, " result"}, o_data0, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold"}, {o_valid, i_ready, 30'd0, o_data0},
                {1'b1, 1'b0, 30'd0, exp});
        end
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        chk({tag, " release"}, {30'd0, o_valid, i_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] xr;
        logic [31:0] yv;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        i_data0  = '0;
        i_valid  = 1'b0;
        o_ready  = 1'b0;
        #1;
        chk("reset outputs", {i_ready, o_valid, o_busy, 29'd0},
            {1'b1, 1'b0, 1'b0, 29'd0});
        chk("reset data", o_data0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op(32'h0000_59F3, 32'h0000_0001, 0, 0, 0, "one");
        do_op(32'hFFFF_A60D, 32'hFFFF_FFFF, 0, 0, 0, "minus1");
        do_op(32'h8000_0000, 32'h8000_0000, 0, 0, 0, "msb");
        do_op(32'h0000_0000, 32'h0000_0000, 0, 0, 0, "zero");
        do_op(32'd2302700000, 32'd100000, 10, 0, 0, "stall");
        do_op(32'd100 * C, 32'd100, 0, 1, 0, "poke");

        // Abort mid-operation.
        @(negedge clk);
        i_data0 = 32'h1234_5678;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("busy mid run", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort state", {i_ready, o_valid, o_busy, 29'd0},
            {1'b1, 1'b0, 1'b0, 29'd0});
        chk("abort data", o_data0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            chk("no spurious valid", {31'd0, o_valid}, 32'd0);
        end
        do_op(32'h0000_59F3, 32'h0000_0001, 0, 0, 0, "after abort");

        for (int n = 0; n < 1000; n++) begin
            xr = $urandom;
            yv = xr * C;
            do_op(yv, xr, int'($urandom_range(0, 3)), 1'($urandom), 1, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult23027_inverter.md
MULT23027_INVERTER -- requirements
Module: mult23027_inverter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports listed clock and reset first.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset; forces reset state immediately, released synchronously to clk by the system.
REQ-004 i_data0  input  32  operand y, a product previously formed as x*23027 mod 2^32.
REQ-005 i_valid  input  1  operand present on i_data0.
REQ-006 i_ready  output  1  block can accept an operand.
REQ-007 o_data0  output  32  recovered factor x, with x*23027 == y mod 2^32.
REQ-008 o_valid  output  1  o_data0 holds a completed result.
REQ-009 o_ready  input  1  downstream accepts the result.
REQ-010 o_busy  output  1  high in RUN state.
REQ-011 Parameter: none; constant C = 23027 (0x000059F3) fixed in the block.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE.
REQ-013 IDLE: i_ready=1, o_valid=0; on i_valid&i_ready, SHALL load residual R<=i_data0, result X<=0, bit counter K<=0, go RUN.
REQ-014 RUN: i_ready=0, o_busy=1; per clock edge SHALL set X[K]<=R[K], and if R[K]=1 set R<=R-(C<<K) mod 2^32; then K<=K+1.
REQ-015 RUN SHALL process exactly 32 bits (K=0..31); the edge processing K=31 SHALL transition to DONE; K is 5 bits and its wrap from 31 to 0 is not used as a termination condition.
REQ-016 All arithmetic SHALL be unsigned modulo 2^32; the shifted constant is truncated to 32 bits.
REQ-017 Invariant in RUN: R == y - X*C mod 2^32 and R[K-1:0]==0; after bit 31, R SHALL be 0.
REQ-018 DONE: o_valid=1, o_data0=X, i_ready=0; o_data0 and o_valid SHALL remain stable while o_ready=0.
REQ-019 DONE with o_ready=1 SHALL return to IDLE on that edge; no new operand is accepted in that same cycle.
REQ-020 Latency: o_valid SHALL assert exactly 32 rising edges after the accepting edge; throughput one operand per 34 cycles minimum.
REQ-021 i_valid while i_ready=0 SHALL be ignored (no queuing); i_data0 changes during RUN SHALL NOT affect the result.
REQ-022 o_ready asserted outside DONE SHALL have no effect.
REQ-023 o_data0 SHALL show X register at all times; its value is meaningful only while o_valid=1.

Reset
REQ-024 On rst=1: state IDLE, R=0, X=0, K=0; outputs i_ready=1, o_valid=0, o_busy=0, o_data0=0.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the operation; the partial result is discarded and no o_valid pulse follows.
REQ-026 First operand SHALL be acceptable on the first rising edge after rst deasserts.

Verification
REQ-027 y=0x000059F3 -> o_data0=0x00000001, o_valid 32 edges after acceptance.
REQ-028 y=0xFFFFA60D -> o_data0=0xFFFFFFFF; y=0x80000000 -> 0x80000000; y=0 -> 0.
REQ-029 y=2302700000 with o_ready held low 10 cycles in DONE -> o_data0=100000 stable throughout, i_ready=0 until cycle after o_ready handshake.
REQ-030 Assert rst at RUN bit 15, then apply y=0x000059F3 -> no spurious o_valid; second result 0x00000001.
REQ-031 i_valid pulsed with new data during RUN -> ignored; result matches first operand.
REQ-032 1000 random x, drive y=x*23027 mod 2^32 back-to-back with random o_ready -> every o_data0 equals x, in order, none lost or duplicated.
